// File: rtl/gpio_apb_ctrl.sv
// APB3 slave front end for the GPIO register block: setup/access sequencing,
// one-cycle write strobe, one wait state on reads. Optional error response: GPIO_APB_SLVERR_EN.
module gpio_apb_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] LAST_REG = 'h24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    input  logic [DATA_W-1:0] reg_rdata
);

    // Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in IDLE;
    // it completes in the cycle where psel=1, penable=1 and pready=1. Dropping psel
    // before that abandons the transfer with no write strobe and no pready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACC  = 2'd1,
        RD_WAIT = 2'd2,
        RD_ACC  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              setup;
    logic              access;
    logic              addr_ok;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] prdata_q;

    assign setup  = psel & ~penable;
    assign access = psel & penable;

    if (LAST_REG[1:0] != 2'b00) begin : g_last_reg_check
        $error("LAST_REG must be word aligned");
    end

`ifdef GPIO_APB_SLVERR_EN
    logic addr_ok_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            addr_ok_q <= 1'b1;
        end else if (state_q == IDLE && setup) begin
            addr_ok_q <= (paddr[1:0] == 2'b00) && (paddr <= LAST_REG);
        end
    end

    assign addr_ok = addr_ok_q;
    assign pslverr = pready & ~addr_ok_q;
`else
    assign addr_ok = 1'b1;
    assign pslverr = 1'b0;
`endif

    assign rd_data = addr_ok ? reg_rdata : '0;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = pwrite ? WR_ACC : RD_WAIT;
            WR_ACC:  state_d = IDLE;
            RD_WAIT: state_d = psel ? RD_ACC : IDLE;
            RD_ACC:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and data are captured only at setup and otherwise held for the block.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else if (state_q == IDLE && setup) begin
            reg_addr  <= paddr;
            reg_wdata <= pwdata;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            prdata_q <= '0;
        end else if (state_q == RD_ACC && access) begin
            prdata_q <= rd_data;
        end
    end

    always_comb begin
        reg_we = 1'b0;
        pready = 1'b0;
        prdata = prdata_q;
        case (state_q)
            WR_ACC: begin
                pready = access;
                reg_we = access & addr_ok;
            end
            RD_ACC: begin
                pready = access;
                prdata = rd_data;
            end
            default: ;
        endcase
    end

endmodule
